lsu: RTL
========

# lsu

Load/store unit: the initiator side of the RAM's data port (port 2). It accepts one RV32I load or store request at a time from the core over a valid/ready handshake and always issues word-aligned accesses. Byte and halfword stores are performed as a read-modify-write; loads are returned extended to 32 bits. Misaligned, out-of-range and illegal-size requests are rejected without touching memory.

## Interface
- `MEM_SIZE`, default 4096, RAM size in bytes; must be a multiple of 4.
- `START_ADDR`, default 0, first valid byte address; must be a multiple of 4.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: core accepts the response.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 2: 00 ok, 01 misaligned, 10 access fault, 11 illegal funct3.
- `mem_addr` out 32: word address to the RAM port; bits [1:0] are always 00.
- `mem_rdata` in 32: combinational RAM read data for `mem_addr`.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out 32: RAM write word.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch the request and check it in this priority order:
  - illegal funct3 -> 11;
  - misaligned -> 01 (H with addr[0]≠0; W with addr[1:0]≠0);
  - out of range -> 10 (aligned word not within [START_ADDR, START_ADDR+MEM_SIZE-1]).
- Error: go to RESP with `rsp_rdata`=0. No memory cycle is issued.
- SW: go to WRITE. Load, SB or SH: go to READ.
- READ: `mem_addr` = the latched addr with bits [1:0] cleared. Capture `mem_rdata`.
  - Load: extract lane addr[1:0] (B) or addr[1] (H), sign- or zero-extend, then go to RESP.
  - SB/SH: merge the store data into the selected lane(s) of the captured word, then go to WRITE.
- WRITE: `mem_we`=1 for exactly one cycle with the merged word (SW: `req_wdata` unmodified), then go to RESP.
- RESP: `rsp_valid`=1. Outputs are held stable until `rsp_ready`; on `rsp_valid && rsp_ready`, go to IDLE.
- `mem_we` is 0 in every state except WRITE, and is gated combinationally with `rst_n`.
- `mem_addr` = 0 when IDLE or RESP.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=00, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Cycle 0 is the accept edge. `rsp_valid` first rises in:
  - cycle 1 for an error;
  - cycle 2 for a load or SW;
  - cycle 3 for SB/SH.
- Throughput: at most one outstanding request. `req_ready`=0 from the accept edge until the response handshake; the next accept can occur the cycle after `rsp_ready`.
- `req_*` inputs are don't-care after accept; latched copies are used throughout.
- Reset asserted mid-operation (any state): `mem_we` drops immediately, state is IDLE after the edge, the pending response is discarded, and no partial write occurs.
- Width rules: lane shift = addr[1:0]×8. Range check is computed with 33-bit arithmetic so that addr+3 cannot wrap.

## Structure
- `lsu_pkg` holds:
  - `funct3` localparams;
  - `lsu_state_e` (IDLE/READ/WRITE/RESP);
  - `lsu_err_e` (OK/MISALIGNED/FAULT/ILLEGAL).
- `lsu_lane` is the one natural sub-module: combinational load extract/extend and store merge, with inputs word, offset, funct3 and wdata.
- The FSM, latches and checks live in `lsu`.

## Test plan
All scenarios start with the RAM word at 0x100 = 0x8899AABB and `rsp_ready`=1 unless stated.
- LW 0x100 -> `mem_addr`=0x100 in cycle 1; `rsp_rdata`=0x8899AABB, `rsp_err`=00 in cycle 2; `mem_we` never 1.
- Extract and extend:
  - LB 0x103 -> 0xFFFFFF88;
  - LBU 0x103 -> 0x00000088;
  - LH 0x102 -> 0xFFFF8899;
  - LHU 0x100 -> 0x0000AABB.
- SB 0x101 with wdata 0x12345677 -> READ in cycle 1, `mem_we`=1 with `mem_wdata`=0x889977BB in cycle 2, response in cycle 3; a following LW 0x100 returns 0x889977BB.
- Errors, each with no memory access and the response in cycle 1:
  - LW 0x102 -> `rsp_err`=01;
  - SW to START_ADDR+MEM_SIZE -> 10;
  - load with funct3 011 -> 11;
  - `mem_we` stays 0 throughout.
- Hold `rsp_ready`=0 for 3 cycles after a LW -> `rsp_valid`/`rsp_rdata` stable and `req_ready`=0; a second request is accepted the cycle after `rsp_ready`.
- Drive `rst_n` low during the WRITE cycle of an SH -> `mem_we`=0 in that cycle, the RAM word is unchanged, and after the edge `req_ready`=1 and `rsp_valid`=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states, error codes and request legality check
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        OK         = 2'b00,
        MISALIGNED = 2'b01,
        FAULT      = 2'b10,
        ILLEGAL    = 2'b11
    } lsu_err_e;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                  : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: byte/halfword lane extraction with extension for loads, lane merge for stores
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [4:0]  shift;
    logic [31:0] lane;
    logic [31:0] mask;

    // Shift the addressed lane down for loads and build the lane mask for stores.
    always_comb begin
        shift      = {offset, 3'b000};
        lane       = word >> shift;
        load_data  = funct3 == F3_B  ? {{24{lane[7]}}, lane[7:0]}   :
                     funct3 == F3_BU ? {24'h0, lane[7:0]}           :
                     funct3 == F3_H  ? {{16{lane[15]}}, lane[15:0]} :
                     funct3 == F3_HU ? {16'h0, lane[15:0]}          : word;
        mask       = (funct3[1:0] == 2'b00 ? 32'h0000_00FF :
                      funct3[1:0] == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << shift;
        store_word = (word & ~mask) | ((wdata << shift) & mask);
    end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding RV32I load/store unit driving a word-wide RAM port
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE   = 4096,
    parameter logic [31:0] START_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata
);

    localparam logic [32:0] LO = {1'b0, START_ADDR};
    localparam logic [32:0] HI = {1'b0, START_ADDR} + 33'(MEM_SIZE) - 33'd1;

    lsu_state_e  state, state_n;
    lsu_err_e    err_q, chk_err;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wword_q;
    logic [31:0] rdata_q;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic [32:0] word_lo;
    logic [32:0] word_hi;
    logic [33:0] below;
    logic        misaligned;
    logic        fault;

    lsu_lane u_lane (
        .word      (mem_rdata),
        .offset    (addr_q[1:0]),
        .funct3    (f3_q),
        .wdata     (wword_q),
        .load_data (load_data),
        .store_word(store_word)
    );

    // Classify the incoming request; 33/34-bit math keeps addr+3 and the lower bound from wrapping.
    always_comb begin
        word_lo    = {1'b0, req_addr[31:2], 2'b00};
        word_hi    = word_lo + 33'd3;
        below      = {1'b0, word_lo} - {1'b0, LO};
        misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        fault      = below[33] || word_hi > HI;
        chk_err    = !f3_legal(req_we, req_funct3) ? ILLEGAL    :
                     misaligned                    ? MISALIGNED :
                     fault                         ? FAULT      : OK;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Latch the request on accept, then capture the load result or merged store word in READ.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wword_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= OK;
        end else if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wword_q <= req_wdata;
            rdata_q <= 32'h0;
            err_q   <= chk_err;
        end else if (state == READ) begin
            if (we_q)
                wword_q <= store_word;
            else
                rdata_q <= load_data;
        end
    end

    // Next state and RAM/handshake outputs; mem_we is gated with rst_n so a reset in WRITE never commits.
    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_n = chk_err != OK                  ? RESP  :
                              req_we && req_funct3 == F3_W   ? WRITE : READ;
            end
            READ: begin
                mem_addr = {addr_q[31:2], 2'b00};
                state_n  = we_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_we    = rst_n;
                mem_wdata = wword_q;
                state_n   = RESP;
            end
            default: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_n = IDLE;
            end
        endcase
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
